// File: rtl/ldtu_olink_pkg.sv
// Shared constants and encodings for the LDTU output-link slot scheduler.
// The slot type also records whether a sync slot terminates a flush.
package ldtu_olink_pkg;

  localparam logic [31:0] IDLE_WORD = 32'hEAAAAAAA;
  localparam logic [31:0] SYNC_WORD = 32'h5A5A5A5A;
  localparam int          CNT_W     = 16;
  localparam int          OVF_W     = 8;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_DATA  = 2'd1,
    SLOT_SYNC  = 2'd2,
    SLOT_FSYNC = 2'd3
  } slot_e;

endpackage

// File: rtl/ldtu_sync_timer.sv
// Counts decided slots since the last sync and flags when a sync is due.
// The count parks at the last value so a flush can never make it wrap.
module ldtu_sync_timer
  import ldtu_olink_pkg::*;
#(
  parameter int SYNC_PERIOD = 256
) (
  input  logic CLK,
  input  logic rst_b,
  input  logic slot_decided,
  input  logic sync_slot,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SYNC_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (slot_decided) begin
      if (sync_slot) begin
        cnt_d = '0;
      end else if (cnt_q != LAST) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/ldtu_olink_sched.sv
// Chooses sync, data or idle for each serializer slot and presents the word
// two cycles after the slot strobe; FIFO data is passed through in CAPTURE.
module ldtu_olink_sched
  import ldtu_olink_pkg::*;
#(
  parameter int          SYNC_PERIOD  = 256,
  parameter logic [31:0] IDLE_PATTERN = IDLE_WORD,
  parameter logic [31:0] SYNC_PATTERN = SYNC_WORD
) (
  input  logic             CLK,
  input  logic             rst_b,
  input  logic             slot_strobe,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  input  logic [31:0]      fifo_data,
  input  logic             sync_req,
  input  logic             flush_req,
  output logic             read_signal,
  output logic [31:0]      dout,
  output logic             dout_valid,
  output logic             flush_done,
  output logic             strobe_err,
  output logic [OVF_W-1:0] ovf_cnt
);

  state_e            state_q, state_d;
  slot_e             slot_q, slot_d;
  logic              read_q, read_d;
  logic [31:0]       dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              fdone_q, fdone_d;
  logic              serr_q, serr_d;
  logic [OVF_W-1:0]  ovf_q, ovf_d;
  logic              full_prev_q, full_prev_d;
  logic              pending_q, pending_d;
  logic              flush_q, flush_d;
  logic              decide, sync_slot, expired;

  ldtu_sync_timer #(.SYNC_PERIOD(SYNC_PERIOD)) u_sync_timer (
    .CLK          (CLK),
    .rst_b        (rst_b),
    .slot_decided (decide),
    .sync_slot    (sync_slot),
    .expired      (expired)
  );

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    read_d      = 1'b0;
    dout_d      = dout_q;
    valid_d     = 1'b0;
    fdone_d     = 1'b0;
    serr_d      = serr_q | (slot_strobe && state_q != ST_WAIT);
    ovf_d       = ovf_q;
    full_prev_d = fifo_full;
    pending_d   = pending_q | sync_req | expired;
    flush_d     = flush_q | flush_req;
    decide      = 1'b0;
    sync_slot   = 1'b0;

    if (fifo_full && !full_prev_q && ovf_q != {OVF_W{1'b1}}) begin
      ovf_d = ovf_q + 1'b1;
    end

    case (state_q)
      ST_WAIT: begin
        if (slot_strobe) begin
          decide  = 1'b1;
          state_d = ST_READ;
          // While flushing, data outranks sync and an empty FIFO ends the flush.
          if (flush_q) begin
            slot_d = fifo_empty ? SLOT_FSYNC : SLOT_DATA;
          end else if (pending_q || expired) begin
            slot_d = SLOT_SYNC;
          end else if (!fifo_empty) begin
            slot_d = SLOT_DATA;
          end else begin
            slot_d = SLOT_IDLE;
          end
          read_d    = (slot_d == SLOT_DATA);
          sync_slot = (slot_d == SLOT_SYNC) || (slot_d == SLOT_FSYNC);
          if (sync_slot) begin
            pending_d = 1'b0;
          end
          if (slot_d == SLOT_FSYNC) begin
            flush_d = 1'b0;
          end
        end
      end
      ST_READ: begin
        state_d = ST_CAPTURE;
        valid_d = 1'b1;
        fdone_d = (slot_q == SLOT_FSYNC);
        if (slot_q == SLOT_IDLE) begin
          dout_d = IDLE_PATTERN;
        end else if (slot_q != SLOT_DATA) begin
          dout_d = SYNC_PATTERN;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_WAIT;
        if (slot_q == SLOT_DATA) begin
          dout_d = fifo_data;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_WAIT;
      slot_q      <= SLOT_IDLE;
      read_q      <= 1'b0;
      dout_q      <= IDLE_PATTERN;
      valid_q     <= 1'b0;
      fdone_q     <= 1'b0;
      serr_q      <= 1'b0;
      ovf_q       <= '0;
      full_prev_q <= 1'b0;
      pending_q   <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      read_q      <= read_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      fdone_q     <= fdone_d;
      serr_q      <= serr_d;
      ovf_q       <= ovf_d;
      full_prev_q <= full_prev_d;
      pending_q   <= pending_d;
      flush_q     <= flush_d;
    end
  end

  assign read_signal = read_q;
  assign dout        = (state_q == ST_CAPTURE && slot_q == SLOT_DATA) ? fifo_data : dout_q;
  assign dout_valid  = valid_q;
  assign flush_done  = fdone_q;
  assign strobe_err  = serr_q;
  assign ovf_cnt     = ovf_q;

endmodule

// File: tb/tb_ldtu_olink_sched.sv
// Scoreboard bench for ldtu_olink_sched with SYNC_PERIOD=4 and a queue-backed FIFO model.
module tb_ldtu_olink_sched;

  localparam logic [31:0] IDLE_W = 32'hEAAAAAAA;
  localparam logic [31:0] SYNC_W = 32'h5A5A5A5A;

  typedef struct packed {
    logic [31:0] word;
    logic        fdone;
  } exp_t;

  logic        CLK = 1'b0;
  logic        rst_b = 1'b0;
  logic        slot_strobe = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_full = 1'b0;
  logic [31:0] fifo_data = 32'h0;
  logic        sync_req = 1'b0;
  logic        flush_req = 1'b0;
  logic        read_signal, dout_valid, flush_done, strobe_err;
  logic [31:0] dout;
  logic [7:0]  ovf_cnt;

  int   vectors = 0;
  int   errors = 0;
  int   rd_cnt = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [31:0] fq[$];

  ldtu_olink_sched #(.SYNC_PERIOD(4)) dut (
    .CLK         (CLK),
    .rst_b       (rst_b),
    .slot_strobe (slot_strobe),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .fifo_data   (fifo_data),
    .sync_req    (sync_req),
    .flush_req   (flush_req),
    .read_signal (read_signal),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .flush_done  (flush_done),
    .strobe_err  (strobe_err),
    .ovf_cnt     (ovf_cnt)
  );

  always #5 CLK = ~CLK;

  // FIFO model pops on each read strobe; scoreboard pops on each valid slot word.
  always @(negedge CLK) begin
    if (read_signal) begin
      rd_cnt++;
      vectors++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL read_on_empty: read_signal=1 with empty FIFO, required 0");
      end else begin
        fifo_data = fq.pop_front();
      end
      fifo_empty = (fq.size() == 0);
    end
    if (rst_b && dout_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: dout=%h with no slot outstanding", dout);
      end else begin
        mon_e = exp_q.pop_front();
        if (dout !== mon_e.word || flush_done !== mon_e.fdone) begin
          errors++;
          $display("FAIL slot_word: dout=%h flush_done=%b, required dout=%h flush_done=%b",
                   dout, flush_done, mon_e.word, mon_e.fdone);
        end else begin
          $display("slot dout=%h flush_done=%b ok", dout, flush_done);
        end
      end
    end
    if (rst_b && flush_done && !dout_valid) begin
      vectors++;
      errors++;
      $display("FAIL flush_done_stray: flush_done=1 with dout_valid=0, required 0");
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    slot_strobe = 1'b0;
    sync_req = 1'b0;
    flush_req = 1'b0;
    fifo_full = 1'b0;
    fq.delete();
    fifo_empty = 1'b1;
    tick(2);
    rst_b = 1'b1;
    tick(1);
  endtask

  task automatic load(input logic [31:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] w, input logic fd);
    exp_t e;
    e.word = w;
    e.fdone = fd;
    exp_q.push_back(e);
  endtask

  // One slot strobe every 4 cycles; optionally raises sync_req in the READ cycle.
  task automatic slot(input bit sync_in_read);
    slot_strobe = 1'b1;
    tick(1);
    slot_strobe = 1'b0;
    vectors++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_valid: dout_valid=%b one cycle after strobe, required 0", dout_valid);
    end
    if (sync_in_read) sync_req = 1'b1;
    tick(1);
    sync_req = 1'b0;
    vectors++;
    if (dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: dout_valid=%b two cycles after strobe, required 1", dout_valid);
    end
    tick(2);
  endtask

  task automatic check_reads(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: read pulses=%0d, required %0d", name, got, want);
    end else begin
      $display("%s read pulses=%0d ok", name, got);
    end
  endtask

  task automatic drain_check(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: %0d slots never produced, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    tick(2);
    vectors++;
    if (read_signal !== 1'b0 || dout_valid !== 1'b0 || dout !== IDLE_W ||
        flush_done !== 1'b0 || strobe_err !== 1'b0 || ovf_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: rd=%b v=%b dout=%h fd=%b se=%b ovf=%0d, required 0 0 %h 0 0 0",
               read_signal, dout_valid, dout, flush_done, strobe_err, ovf_cnt, IDLE_W);
    end else begin
      $display("reset state ok");
    end
    rst_b = 1'b1;
    tick(1);
  endtask

  task automatic test_idle();
    int r0;
    do_reset();
    r0 = rd_cnt;
    push_exp(IDLE_W, 1'b0);
    push_exp(IDLE_W, 1'b0);
    push_exp(IDLE_W, 1'b0);
    push_exp(SYNC_W, 1'b0);
    push_exp(IDLE_W, 1'b0);
    repeat (5) slot(1'b0);
    check_reads("idle", rd_cnt - r0, 0);
    drain_check("idle");
  endtask

  task automatic test_data_sync();
    int r0;
    do_reset();
    r0 = rd_cnt;
    load(32'h1111_0001);
    load(32'h2222_0002);
    load(32'h3333_0003);
    push_exp(32'h1111_0001, 1'b0);
    push_exp(32'h2222_0002, 1'b0);
    push_exp(32'h3333_0003, 1'b0);
    push_exp(SYNC_W, 1'b0);
    push_exp(IDLE_W, 1'b0);
    repeat (5) slot(1'b0);
    check_reads("data_sync", rd_cnt - r0, 3);
    drain_check("data_sync");
  endtask

  task automatic test_sync_coincide();
    int r0;
    do_reset();
    r0 = rd_cnt;
    for (int i = 0; i < 6; i++) load(32'hA000_0000 + 32'(i));
    for (int i = 0; i < 3; i++) push_exp(32'hA000_0000 + 32'(i), 1'b0);
    push_exp(SYNC_W, 1'b0);
    for (int i = 3; i < 6; i++) push_exp(32'hA000_0000 + 32'(i), 1'b0);
    push_exp(SYNC_W, 1'b0);
    slot(1'b0);
    slot(1'b0);
    slot(1'b1);
    repeat (5) slot(1'b0);
    check_reads("sync_coincide", rd_cnt - r0, 6);
    drain_check("sync_coincide");
  endtask

  task automatic test_flush();
    int r0;
    do_reset();
    r0 = rd_cnt;
    load(32'hF00D_0001);
    load(32'hF00D_0002);
    sync_req = 1'b1;
    tick(1);
    sync_req = 1'b0;
    flush_req = 1'b1;
    tick(1);
    flush_req = 1'b0;
    tick(1);
    flush_req = 1'b1;
    tick(1);
    flush_req = 1'b0;
    push_exp(32'hF00D_0001, 1'b0);
    push_exp(32'hF00D_0002, 1'b0);
    push_exp(SYNC_W, 1'b1);
    push_exp(IDLE_W, 1'b0);
    repeat (4) slot(1'b0);
    check_reads("flush", rd_cnt - r0, 2);
    drain_check("flush");
  endtask

  task automatic test_strobe_err();
    do_reset();
    vectors++;
    if (strobe_err !== 1'b0) begin
      errors++;
      $display("FAIL strobe_err_clear: strobe_err=%b, required 0", strobe_err);
    end
    push_exp(IDLE_W, 1'b0);
    slot_strobe = 1'b1;
    tick(2);
    slot_strobe = 1'b0;
    vectors++;
    if (strobe_err !== 1'b1) begin
      errors++;
      $display("FAIL strobe_err_set: strobe_err=%b, required 1", strobe_err);
    end
    tick(2);
    push_exp(IDLE_W, 1'b0);
    slot(1'b0);
    vectors++;
    if (strobe_err !== 1'b1) begin
      errors++;
      $display("FAIL strobe_err_sticky: strobe_err=%b, required 1", strobe_err);
    end else begin
      $display("strobe_err sticky ok");
    end
    drain_check("strobe_err");
  endtask

  task automatic test_ovf();
    do_reset();
    fifo_full = 1'b1;
    tick(3);
    fifo_full = 1'b0;
    tick(1);
    repeat (9) begin
      fifo_full = 1'b1;
      tick(1);
      fifo_full = 1'b0;
      tick(1);
    end
    vectors++;
    if (ovf_cnt !== 8'd10) begin
      errors++;
      $display("FAIL ovf_count: ovf_cnt=%0d, required 10", ovf_cnt);
    end else begin
      $display("ovf_cnt=10 ok");
    end
    repeat (291) begin
      fifo_full = 1'b1;
      tick(1);
      fifo_full = 1'b0;
      tick(1);
    end
    vectors++;
    if (ovf_cnt !== 8'd255) begin
      errors++;
      $display("FAIL ovf_saturate: ovf_cnt=%0d, required 255", ovf_cnt);
    end else begin
      $display("ovf_cnt=255 ok");
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    do_reset();
    repeat (3) begin
      fifo_full = 1'b1;
      tick(1);
      fifo_full = 1'b0;
      tick(1);
    end
    load(32'hCAFE_0042);
    slot_strobe = 1'b1;
    @(posedge CLK);
    #2;
    slot_strobe = 1'b0;
    vectors++;
    if (read_signal !== 1'b1) begin
      errors++;
      $display("FAIL mid_read: read_signal=%b before reset, required 1", read_signal);
    end
    rst_b = 1'b0;
    #1;
    vectors++;
    if (read_signal !== 1'b0 || dout_valid !== 1'b0 || dout !== IDLE_W ||
        flush_done !== 1'b0 || ovf_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: rd=%b v=%b dout=%h fd=%b ovf=%0d, required 0 0 %h 0 0",
               read_signal, dout_valid, dout, flush_done, ovf_cnt, IDLE_W);
    end else begin
      $display("async reset mid-slot ok");
    end
    tick(2);
    rst_b = 1'b1;
    r0 = rd_cnt;
    tick(6);
    check_reads("post_reset_quiet", rd_cnt - r0, 0);
    push_exp(32'hCAFE_0042, 1'b0);
    slot(1'b0);
    check_reads("post_reset_slot", rd_cnt - r0, 1);
    drain_check("reset_mid");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_data_sync();
    test_sync_coincide();
    test_flush();
    test_strobe_err();
    test_ovf();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ldtu_olink_sched.md
LDTU_OLINK_SCHED -- requirements
Module: ldtu_olink_sched

Interface
REQ-001 Parameter SYNC_PERIOD, default 256, number of slots between automatic sync words (range 4..65535).
REQ-002 Parameter IDLE_PATTERN, default 32'hEAAAAAAA, word emitted when no data is available.
REQ-003 Parameter SYNC_PATTERN, default 32'h5A5A5A5A, word emitted for a sync slot.
REQ-004 CLK  input  1  sole clock, all logic rising-edge.
REQ-005 rst_b  input  1  asynchronous active-low reset.
REQ-006 slot_strobe  input  1  one-cycle pulse per 32-bit serializer slot.
REQ-007 fifo_empty  input  1  output FIFO empty flag.
REQ-008 fifo_full  input  1  output FIFO full flag.
REQ-009 fifo_data  input  32  FIFO word, valid the cycle after read_signal.
REQ-010 sync_req  input  1  external one-cycle sync request.
REQ-011 flush_req  input  1  one-cycle request to drain the FIFO.
REQ-012 read_signal  output  1  one-cycle FIFO read strobe.
REQ-013 dout  output  32  slot word to serializer.
REQ-014 dout_valid  output  1  one-cycle qualifier of dout.
REQ-015 flush_done  output  1  one-cycle pulse at end of flush.
REQ-016 strobe_err  output  1  sticky flag: slot_strobe arrived while not in WAIT.
REQ-017 ovf_cnt  output  8  saturating count of fifo_full rising edges.

Function
REQ-018 FSM states WAIT, READ, CAPTURE; WAIT->READ on slot_strobe, READ->CAPTURE unconditionally, CAPTURE->WAIT unconditionally.
REQ-019 Slot decision is made in the slot_strobe cycle; priority: pending sync > data (fifo_empty=0) > idle.
REQ-020 Data slot: read_signal=1 exactly in the READ cycle; no other cycle asserts read_signal.
REQ-021 Every slot type: dout updated and dout_valid=1 in the CAPTURE cycle (latency 2 cycles from slot_strobe); dout holds value otherwise.
REQ-022 Data slot dout = fifo_data sampled in CAPTURE; idle slot dout = IDLE_PATTERN; sync slot dout = SYNC_PATTERN.
REQ-023 Sync pending set by sync_req (any state) or by slot counter reaching SYNC_PERIOD-1; cleared when a sync slot is decided; multiple requests while pending merge into one.
REQ-024 Slot counter counts decided slots of any type, resets to 0 on each sync slot, wraps never (sync forced at SYNC_PERIOD-1).
REQ-025 sync_req and counter-expiry in the same cycle produce one sync slot.
REQ-026 flush_req sets flush mode: data priority raised above sync; when a slot is decided with fifo_empty=1, that slot is a sync, flush mode clears, flush_done pulses in its CAPTURE cycle.
REQ-027 flush_req while already flushing is ignored; sync_req during flush stays pending and is satisfied by the flush-terminating sync.
REQ-028 slot_strobe in READ or CAPTURE is ignored and sets strobe_err until reset.
REQ-029 ovf_cnt increments on each 0->1 transition of fifo_full, saturating at 255.

Reset
REQ-030 rst_b low asynchronously forces: state WAIT, read_signal 0, dout IDLE_PATTERN, dout_valid 0, flush_done 0, strobe_err 0, ovf_cnt 0, slot counter 0, sync pending 0, flush mode 0.
REQ-031 Reset mid-slot aborts the slot; no read_signal or dout_valid is produced after release until a new slot_strobe.

Structure
REQ-032 Shared package ldtu_olink_pkg holds IDLE/SYNC pattern constants, state encoding, slot-type encoding and counter widths.
REQ-033 One sub-module ldtu_sync_timer (slot counter plus expiry flag) instantiated once.

Verification
REQ-034 FIFO empty, strobes every 4 cycles -> dout 32'hEAAAAAAA, dout_valid 2 cycles after each strobe, read_signal never high.
REQ-035 FIFO holds 3 words, SYNC_PERIOD=4 -> slots: data, data, data, sync(32'h5A5A5A5A), idle; read_signal exactly 3 pulses.
REQ-036 sync_req and counter expiry same cycle with FIFO non-empty -> one sync slot, then data resumes, counter restarts at 0.
REQ-037 flush_req with 2 words + sync pending -> data, data, sync, flush_done in the sync CAPTURE cycle, single sync only.
REQ-038 slot_strobe in READ cycle -> ignored, strobe_err=1 sticky; fifo_full toggled 300 times -> ovf_cnt=255.
REQ-039 rst_b low during READ -> all outputs at reset values immediately; no dout_valid until next strobe +2.
